// File: rtl/tdm_demux8.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux8
// Purpose  : TDM serial-to-parallel demultiplexer with per-channel registers
//            and atomic per-frame publication on frame_out.
//            Optional even-parity slot enabled by TDM_DEMUX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux8 #(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_sync,
  input  logic             err_clr,
  output logic [N_CH-1:0]  ch_out,
  output logic [N_CH-1:0]  frame_out,
  output logic             frame_valid,
  output logic [SEL_W:0]   slot,
  output logic             locked,
  output logic             sync_err,
  output logic             parity_err
);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [SEL_W:0] c_NCH = (SEL_W+1)'(N_CH);
`ifdef TDM_DEMUX_PARITY_EN
  localparam logic [SEL_W:0] c_LAST = (SEL_W+1)'(N_CH);
`else
  localparam logic [SEL_W:0] c_LAST = (SEL_W+1)'(N_CH - 1);
`endif

  state_t            state_q, state_d;
  logic [SEL_W:0]    slot_q, slot_d;
  logic [N_CH-1:0]   ch_q, ch_d;
  logic [N_CH-1:0]   shadow_q, shadow_d;
  logic [N_CH-1:0]   frame_q, frame_d;
  logic              fv_q, fv_d;
  logic              serr_q, serr_d;
`ifdef TDM_DEMUX_PARITY_EN
  logic              par_q, par_d;
  logic              perr_q, perr_d;
`endif

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    ch_d     = ch_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    fv_d     = 1'b0;
    // Clear first so that a sync error in the same cycle overrides err_clr.
    serr_d   = serr_q & ~err_clr;
`ifdef TDM_DEMUX_PARITY_EN
    par_d    = par_q;
    perr_d   = perr_q;
`endif
    if (din_valid) begin
      if (frame_sync) begin
        if ((state_q == RUN) && (slot_q != '0)) begin
          serr_d = 1'b1;
        end
        ch_d[0]     = din;
        shadow_d[0] = din;
        slot_d      = (SEL_W+1)'(1);
        state_d     = RUN;
`ifdef TDM_DEMUX_PARITY_EN
        par_d       = din;
`endif
      end else if (state_q == RUN) begin
        if (slot_q < c_NCH) begin
          ch_d[slot_q[SEL_W-1:0]]     = din;
          shadow_d[slot_q[SEL_W-1:0]] = din;
        end
`ifdef TDM_DEMUX_PARITY_EN
        par_d = (slot_q == '0) ? din : (par_q ^ din);
`endif
        if (slot_q == c_LAST) begin
          frame_d = shadow_d;
          fv_d    = 1'b1;
          slot_d  = '0;
`ifdef TDM_DEMUX_PARITY_EN
          perr_d  = par_q ^ din;
`endif
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      slot_q   <= '0;
      ch_q     <= '0;
      shadow_q <= '0;
      frame_q  <= '0;
      fv_q     <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      ch_q     <= ch_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      fv_q     <= fv_d;
      serr_q   <= serr_d;
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign ch_out      = ch_q;
  assign frame_out   = frame_q;
  assign frame_valid = fv_q;
  assign slot        = slot_q;
  assign locked      = (state_q == RUN);
  assign sync_err    = serr_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux8.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux8
// Purpose  : Scoreboard bench for tdm_demux8 (frames queued when driven,
//            compared when frame_valid pulses).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux8;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             din = 1'b0;
  logic             din_valid = 1'b0;
  logic             frame_sync = 1'b0;
  logic             err_clr = 1'b0;
  logic [N_CH-1:0]  ch_out;
  logic [N_CH-1:0]  frame_out;
  logic             frame_valid;
  logic [SEL_W:0]   slot;
  logic             locked;
  logic             sync_err;
  logic             parity_err;

  typedef struct packed {
    logic [7:0] frame;
    logic       perr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   fv_cnt = 0;
  logic fv_prev = 1'b0;

  tdm_demux8 #(.N_CH(N_CH), .SEL_W(SEL_W)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .err_clr     (err_clr),
    .ch_out      (ch_out),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .slot        (slot),
    .locked      (locked),
    .sync_err    (sync_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard consumer: every frame_valid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      fv_cnt++;
      chk("fv_single", {31'd0, fv_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("fv_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("frame_out", {24'd0, frame_out}, {24'd0, e.frame});
        chk("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
      end
    end
    fv_prev <= frame_valid;
  end

  task automatic beat(input logic s, input logic d);
    @(negedge clk);
    frame_sync = s;
    din        = d;
    din_valid  = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    frame_sync = 1'b0;
    din_valid  = 1'b0;
  endtask

  task automatic do_reset();
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ch_out", {24'd0, ch_out}, 32'd0);
    chk("rst_frame_out", {24'd0, frame_out}, 32'd0);
    chk("rst_fv", {31'd0, frame_valid}, 32'd0);
    chk("rst_slot", {28'd0, slot}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_sync_err", {31'd0, sync_err}, 32'd0);
    chk("rst_parity_err", {31'd0, parity_err}, 32'd0);
    rst_n = 1'b1;
  endtask

  // Sends one full frame starting with a sync beat; pbad corrupts the parity bit.
  task automatic send_frame(input logic [7:0] val, input bit gaps, input bit pbad);
    exp_t e;
    e.frame = val;
`ifdef TDM_DEMUX_PARITY_EN
    e.perr = pbad;
`else
    e.perr = 1'b0;
`endif
    exp_q.push_back(e);
    for (int i = 0; i < N_CH; i++) begin
      beat(i == 0, val[i]);
      if (gaps) begin
        idle();
        chk("ch_track", {31'd0, ch_out[i]}, {31'd0, val[i]});
      end
    end
`ifdef TDM_DEMUX_PARITY_EN
    @(negedge clk);
    chk("fv_before_parity", {31'd0, frame_valid}, 32'd0);
    frame_sync = 1'b0;
    din        = (^val) ^ pbad;
    din_valid  = 1'b1;
    if (gaps) idle();
`endif
  endtask

  initial begin
    int fv0;
    // 1. reset then lock
    do_reset();
    fv0 = fv_cnt;
    send_frame(8'h4D, 1'b0, 1'b0);
    idle();
    chk("t1_frame_out", {24'd0, frame_out}, 32'h4D);
    chk("t1_locked", {31'd0, locked}, 32'd1);
    chk("t1_slot", {28'd0, slot}, 32'd0);
    idle();
    chk("t1_fv_count", fv_cnt - fv0, 32'd1);

    // 2. hunt filter
    do_reset();
    fv0 = fv_cnt;
    for (int i = 0; i < 5; i++) beat(1'b0, 1'b1);
    idle();
    chk("t2_ch_out", {24'd0, ch_out}, 32'd0);
    chk("t2_slot", {28'd0, slot}, 32'd0);
    chk("t2_locked", {31'd0, locked}, 32'd0);
    idle();
    chk("t2_fv_count", fv_cnt - fv0, 32'd0);

    // 3. gapped frame then back-to-back frame
    fv0 = fv_cnt;
    send_frame(8'hA5, 1'b1, 1'b0);
    chk("t3_frame_a5", {24'd0, frame_out}, 32'hA5);
    send_frame(8'h3C, 1'b0, 1'b0);
    idle();
    chk("t3_frame_3c", {24'd0, frame_out}, 32'h3C);
    idle();
    chk("t3_fv_count", fv_cnt - fv0, 32'd2);

    // 4. mid-frame sync
    fv0 = fv_cnt;
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b0);
    idle();
    chk("t4_slot_partial", {28'd0, slot}, 32'd4);
    chk("t4_no_err_yet", {31'd0, sync_err}, 32'd0);
    send_frame(8'hE1, 1'b0, 1'b0);
    idle();
    chk("t4_sync_err", {31'd0, sync_err}, 32'd1);
    chk("t4_bit0", {31'd0, frame_out[0]}, 32'd1);
    idle();
    chk("t4_fv_count", fv_cnt - fv0, 32'd1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t4_err_clr", {31'd0, sync_err}, 32'd0);
    // err_clr coinciding with a new mid-frame sync: set wins
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    @(negedge clk);
    frame_sync = 1'b1;
    din        = 1'b1;
    din_valid  = 1'b1;
    err_clr    = 1'b1;
    @(negedge clk);
    err_clr    = 1'b0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    chk("t4_set_wins", {31'd0, sync_err}, 32'd1);

    // 5. async reset mid-frame (slot is 1 here)
    for (int i = 0; i < 4; i++) beat(1'b0, 1'b1);
    @(posedge clk);
    #2;
    chk("t5_slot_before", {28'd0, slot}, 32'd5);
    rst_n     = 1'b0;
    din_valid = 1'b0;
    #1;
    chk("t5_ch_out", {24'd0, ch_out}, 32'd0);
    chk("t5_frame_out", {24'd0, frame_out}, 32'd0);
    chk("t5_slot", {28'd0, slot}, 32'd0);
    chk("t5_locked", {31'd0, locked}, 32'd0);
    chk("t5_sync_err", {31'd0, sync_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    idle();
    chk("t5_rehunt", {31'd0, locked}, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0);
    idle();
    chk("t5_relock", {31'd0, locked}, 32'd1);

`ifdef TDM_DEMUX_PARITY_EN
    // 6. parity slot
    send_frame(8'h0F, 1'b0, 1'b0);
    idle();
    chk("t6_perr_ok", {31'd0, parity_err}, 32'd0);
    send_frame(8'h07, 1'b0, 1'b1);
    idle();
    chk("t6_perr_bad", {31'd0, parity_err}, 32'd1);
    chk("t6_frame", {24'd0, frame_out}, 32'h07);
`endif

    repeat (20) idle();
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
